// File: rtl/systemizer_feeder_pkg.sv
// Shared definitions for the systolic row feeder: FSM encoding, token sideband layout and
// the start-to-lane-0 latency.
package systemizer_feeder_pkg;

   typedef enum logic [1:0] {IDLE, READ, FLUSH, DRAIN} state_t;

   // Accepted start -> address register -> RAM output -> head register -> lane 0.
   localparam int T0 = 3;

   // Per-lane sideband bits carried beside each element: {data, vld, sof, eof}.
   localparam int TOK_W   = 3;
   localparam int TOK_VLD = 2;
   localparam int TOK_SOF = 1;
   localparam int TOK_EOF = 0;

   typedef struct packed {
      logic fp;
      logic vld;
      logic sof;
      logic eof;
   } tok_t;

   localparam tok_t TOK_IDLE = '{fp: 1'b1, vld: 1'b0, sof: 1'b0, eof: 1'b0};

endpackage

// File: rtl/systemizer_row_feeder_if.sv
// Feeder bus: sweep control handshake, row RAM read port and the per-lane stream to the array.
interface systemizer_row_feeder_if #(
   parameter int WIDTH  = 13,
   parameter int N      = 4,
   parameter int L      = 4,
   parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
);
   logic                start;
   logic                abort;
   logic                busy;
   logic                done;
   logic                aborted;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [L*WIDTH-1:0]  rd_data;
   logic [L*WIDTH-1:0]  data_out;
   logic [L-1:0]        valid_out;
   logic [L-1:0]        start_out;
   logic [L-1:0]        finish_out;
   logic                first_pass_out;

   modport master (
      input  start, abort, rd_data,
      output busy, done, aborted, rd_en, rd_addr,
             data_out, valid_out, start_out, finish_out, first_pass_out
   );

   modport slave (
      output start, abort, rd_data,
      input  busy, done, aborted, rd_en, rd_addr,
             data_out, valid_out, start_out, finish_out, first_pass_out
   );
endinterface

// File: rtl/feeder_skew_line.sv
// DEPTH-stage delay line for one lane's element plus tokens; DEPTH=0 is a plain wire.
module feeder_skew_line #(
   parameter int DEPTH = 1,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst_n, flush};
         assign q = d;
      end else begin : g_sr
         logic [DEPTH-1:0][W-1:0] sr;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr <= '0;
            end else if (flush) begin
               sr <= '0;
            end else begin
               sr[0] <= d;
               for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
            end
         end
         assign q = sr[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/systemizer_row_feeder.sv
// Row feeder: reads a row-major RAM and injects diagonally skewed rows framed by start/finish
// tokens. Build option FEEDER_TWO_PASS_EN runs a second sweep, clearing first_pass_out for it.
module systemizer_row_feeder
   import systemizer_feeder_pkg::*;
#(
   parameter int WIDTH  = 13,
   parameter int N      = 4,
   parameter int L      = 4,
   parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
   input logic                      clk,
   input logic                      rst_n,
   systemizer_row_feeder_if.master  bus
);
   localparam int DRN_W = (L > 1) ? $clog2(L) : 1;

   state_t                  state;
   logic [ADDR_W-1:0]       rd_addr;
   logic [DRN_W-1:0]        drain;
   logic                    rd_en, fin, pass2, busy, done, aborted;
   logic                    abort_take;
   tok_t                    issue;
   tok_t                    tok_q [1:T0-1];
   logic [L-1:0][WIDTH-1:0] head_row;
   logic [WIDTH+TOK_W-1:0]  lane_q [L];
   logic [L-1:0][WIDTH-1:0] data_o;
   logic [L-1:0]            vld_o, sof_o, eof_o;

   assign abort_take = bus.abort && (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rd_addr <= '0;
         drain   <= '0;
         rd_en   <= 1'b0;
         fin     <= 1'b0;
         pass2   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else if (abort_take) begin
         state   <= IDLE;
         rd_en   <= 1'b0;
         fin     <= 1'b0;
         pass2   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b1;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         fin     <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state   <= READ;
               busy    <= 1'b1;
               rd_en   <= 1'b1;
               rd_addr <= '0;
               pass2   <= 1'b0;
            end
            READ: if (rd_addr == ADDR_W'(N-1)) begin
               state <= FLUSH;
               rd_en <= 1'b0;
               fin   <= 1'b1;
            end else begin
               rd_addr <= rd_addr + ADDR_W'(1);
            end
            FLUSH: begin
`ifdef FEEDER_TWO_PASS_EN
               // Pass 2 rows follow the pass 1 finish slot back to back.
               if (!pass2) begin
                  state   <= READ;
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
                  pass2   <= 1'b1;
               end else
`endif
               if (tok_q[T0-1].eof) begin
                  if (L == 1) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                     drain <= '0;
                  end
               end
            end
            DRAIN: if (drain == DRN_W'(L-2)) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               drain <= drain + DRN_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      issue     = TOK_IDLE;
      issue.vld = rd_en | fin;
      issue.sof = rd_en && (rd_addr == '0);
      issue.eof = fin;
      issue.fp  = !(pass2 && (rd_en | fin));
   end

   // Tokens ride alongside the RAM latency so they meet their row at the head register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k < T0; k++) tok_q[k] <= TOK_IDLE;
         head_row <= '0;
      end else if (abort_take) begin
         for (int k = 1; k < T0; k++) tok_q[k] <= TOK_IDLE;
         head_row <= '0;
      end else begin
         tok_q[1] <= issue;
         for (int k = 2; k < T0; k++) tok_q[k] <= tok_q[k-1];
         head_row <= (tok_q[T0-2].vld && !tok_q[T0-2].eof) ? bus.rd_data : '0;
      end
   end

   generate
      for (genvar j = 0; j < L; j++) begin : g_lane
         feeder_skew_line #(.DEPTH(j), .W(WIDTH+TOK_W)) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (abort_take),
            .d     ({head_row[j], tok_q[T0-1].vld, tok_q[T0-1].sof, tok_q[T0-1].eof}),
            .q     (lane_q[j])
         );
      end
   endgenerate

   always_comb begin
      data_o = '0;
      vld_o  = '0;
      sof_o  = '0;
      eof_o  = '0;
      for (int j = 0; j < L; j++) begin
         data_o[j] = lane_q[j][TOK_W +: WIDTH];
         vld_o[j]  = lane_q[j][TOK_VLD];
         sof_o[j]  = lane_q[j][TOK_SOF];
         eof_o[j]  = lane_q[j][TOK_EOF];
      end
   end

   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.aborted        = aborted;
   assign bus.rd_en          = rd_en;
   assign bus.rd_addr        = rd_addr;
   assign bus.data_out       = data_o;
   assign bus.valid_out      = vld_o;
   assign bus.start_out      = sof_o;
   assign bus.finish_out     = eof_o;
   assign bus.first_pass_out = tok_q[T0-1].fp;
endmodule

// File: tb/tb_systemizer_row_feeder.sv
// Bench for the row feeder: two instances (N=4,L=3 and N=1,L=1) with a per-cycle scoreboard.
module tb_systemizer_row_feeder;
   import systemizer_feeder_pkg::*;

   localparam int W   = 13;
   localparam int BA  = 0;
   localparam int BB  = 'h0A00;
   localparam int LEN = 20;
`ifdef FEEDER_TWO_PASS_EN
   localparam int P = 2;
`else
   localparam int P = 1;
`endif

   typedef struct packed {
      logic        busy, done, aborted, rd_en;
      logic [1:0]  addr;
      logic        fp;
      logic [2:0]  vld, sof, eof;
      logic [38:0] data;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   rec_t qa[$];
   rec_t qb[$];

   always #5 clk = ~clk;

   systemizer_row_feeder_if #(.WIDTH(W), .N(4), .L(3)) ia ();
   systemizer_row_feeder_if #(.WIDTH(W), .N(1), .L(1)) ib ();

   systemizer_row_feeder #(.WIDTH(W), .N(4), .L(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   systemizer_row_feeder #(.WIDTH(W), .N(1), .L(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   function automatic logic [38:0] row_word(int base, int l, int addr);
      logic [38:0] w = '0;
      for (int j = 0; j < l; j++) w[j*W +: W] = W'(base + 16*addr + j);
      return w;
   endfunction

   // Row RAM with one cycle of read latency; junk on the bus when not reading.
   always @(posedge clk) begin
      ia.rd_data <= ia.rd_en ? row_word(BA, 3, int'(ia.rd_addr)) : 39'({$urandom, $urandom});
      ib.rd_data <= ib.rd_en ? 13'(row_word(BB, 1, int'(ib.rd_addr))) : 13'($urandom);
   end

   function automatic rec_t idle_rec();
      rec_t r = '0;
      r.fp = 1'b1;
      return r;
   endfunction

   function automatic int done_cyc(int n, int l);
      return T0 + P*(n+1) + l - 1;
   endfunction

   function automatic bit ab_eff(int n, int l, int ab);
      return (ab >= 1) && (ab < done_cyc(n, l));
   endfunction

   function automatic int last_t(int n, int l, int ab);
      return ab_eff(n, l, ab) ? ab + 2 : done_cyc(n, l) + 1;
   endfunction

   // Expected outputs at cycle t after a start accepted at cycle 0.
   function automatic rec_t model(int n, int l, int base, int t, int ab);
      rec_t r = idle_rec();
      int dt = done_cyc(n, l);
      int per = n + 1;
      int slot, rr;
      if (ab_eff(n, l, ab) && t > ab) begin
         r.aborted = (t == ab + 1);
         return r;
      end
      r.busy = (t >= 1) && (t < dt);
      r.done = (t == dt);
      for (int ps = 0; ps < P; ps++)
         if (t >= 1 + ps*per && t <= n + ps*per) begin
            r.rd_en = 1'b1;
            r.addr  = 2'(t - 1 - ps*per);
         end
      for (int j = 0; j < l; j++) begin
         slot = t - T0 - j;
         if (slot >= 0 && slot < P*per) begin
            rr = slot % per;
            r.vld[j] = 1'b1;
            if (rr == n) r.eof[j] = 1'b1;
            else begin
               r.data[j*W +: W] = W'(base + 16*rr + j);
               r.sof[j] = (rr == 0);
            end
            if (j == 0 && slot >= per) r.fp = 1'b0;
         end
      end
      return r;
   endfunction

   task automatic chk(string tag, rec_t act, rec_t exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
      end
   endtask

   task automatic check_now();
      rec_t ea, eb, aa, ab;
      ea = (qa.size() > 0) ? qa.pop_front() : idle_rec();
      eb = (qb.size() > 0) ? qb.pop_front() : idle_rec();
      aa = '0;
      aa.busy = ia.busy; aa.done = ia.done; aa.aborted = ia.aborted; aa.rd_en = ia.rd_en;
      aa.addr = ia.rd_en ? 2'(ia.rd_addr) : 2'b0;
      aa.fp = ia.first_pass_out;
      aa.vld = ia.valid_out; aa.sof = ia.start_out; aa.eof = ia.finish_out;
      aa.data = ia.data_out;
      ab = '0;
      ab.busy = ib.busy; ab.done = ib.done; ab.aborted = ib.aborted; ab.rd_en = ib.rd_en;
      ab.addr = ib.rd_en ? 2'(ib.rd_addr) : 2'b0;
      ab.fp = ib.first_pass_out;
      ab.vld = 3'(ib.valid_out); ab.sof = 3'(ib.start_out); ab.eof = 3'(ib.finish_out);
      ab.data = 39'(ib.data_out);
      chk("dut_a", aa, ea);
      chk("dut_b", ab, eb);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_now();
   endtask

   // One sweep on both instances; s2 = extra start cycle, ab* = abort cycles, rst_at = reset cycle.
   task automatic scenario(int s2, int aba, int abb, int rst_at);
      for (int t = 1; t <= last_t(4, 3, aba); t++) qa.push_back(model(4, 3, BA, t, aba));
      for (int t = 1; t <= last_t(1, 1, abb); t++) qb.push_back(model(1, 1, BB, t, abb));
      for (int c = 0; c < LEN; c++) begin
         if (c == rst_at) begin
            rst_n = 1'b0;
            qa.delete();
            qb.delete();
            #1;
            check_now();
         end
         if (c == rst_at + 2) rst_n = 1'b1;
         ia.start = (c == 0) || (c == s2);
         ib.start = ia.start;
         ia.abort = (c == aba);
         ib.abort = (c == abb);
         tick();
      end
      ia.start = 1'b0; ib.start = 1'b0; ia.abort = 1'b0; ib.abort = 1'b0;
      checks++;
      assert (qa.size() + qb.size() === 0) else begin
         failures++;
         $error("FAIL queue_drain got=%0d want=0", qa.size() + qb.size());
      end
   endtask

   initial begin
      ia.start = 1'b0; ia.abort = 1'b0;
      ib.start = 1'b0; ib.abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_now();
      rst_n = 1'b1;
      tick();
      tick();
      scenario(-1, -1, -1, -1);
      scenario(-1, 6, 2, -1);
      scenario(4, -1, 7, -1);
      scenario(-1, done_cyc(4, 3) - 1, done_cyc(1, 1) - 1, -1);
      scenario(-1, 0, 0, -1);
      scenario(-1, -1, -1, 5);
      scenario(-1, -1, -1, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
